block_store: RTL and testbench

- Write-side counterpart of the block fetcher.
- Accepts one 4096-bit result block per valve/ready handshake and writes it to word-addressed memory as a sequence of WORD_W-bit words at consecutive addresses, starting from a captured base address.
- Sits between the accelerator datapath output and the result memory, and signals completion per block.

---
 rtl/block_store.sv | 113 +++++++++++
 tb/tb_block_store.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/block_store.sv
// Result-block writer: captures one wide block per handshake and streams it to
// word-addressed memory, LSB word first, at consecutive addresses from a base.
module block_store #(
    parameter int BLOCK_W = 4096,
    parameter int WORD_W  = 128,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [ADDR_W-1:0]  in_base,
    output logic               mem_we,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_wdata,
    output logic               busy,
    output logic               done,
    output logic [15:0]        blk_count
);

    localparam int NWORDS = BLOCK_W / WORD_W;
    localparam int KW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t               state_reg, state_next;
    logic [BLOCK_W-1:0]   block_reg, block_next;
    logic [KW-1:0]        k_reg, k_next;
    logic [ADDR_W-1:0]    addr_reg, addr_next;
    logic [WORD_W-1:0]    wdata_reg, wdata_next;
    logic                 we_reg, we_next;
    logic                 ready_reg, ready_next;
    logic [15:0]          count_reg, count_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            block_reg <= '0;
            k_reg     <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
            ready_reg <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            block_reg <= block_next;
            k_reg     <= k_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            we_reg    <= we_next;
            ready_reg <= ready_next;
            count_reg <= count_next;
        end
    end

    // block_reg holds only the words not yet presented, shifted down so the
    // next word to write always sits in the low WORD_W bits.
    always_comb begin
        state_next = state_reg;
        block_next = block_reg;
        k_next     = k_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        we_next    = we_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid && ready_reg) begin
                    state_next = WRITE;
                    block_next = in_data >> WORD_W;
                    wdata_next = in_data[WORD_W-1:0];
                    addr_next  = in_base;
                    we_next    = 1'b1;
                    k_next     = '0;
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    if (k_reg == KW'(NWORDS - 1)) begin
                        state_next = DONE;
                        we_next    = 1'b0;
                        count_next = count_reg + 16'd1;
                    end else begin
                        k_next     = k_reg + KW'(1);
                        addr_next  = addr_reg + ADDR_W'(1);
                        wdata_next = block_reg[WORD_W-1:0];
                        block_next = block_reg >> WORD_W;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                we_next    = 1'b0;
            end
        endcase
        ready_next = (state_next == IDLE);
    end

    assign in_ready  = ready_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign busy      = (state_reg == WRITE);
    assign done      = (state_reg == DONE);
    assign blk_count = count_reg;

endmodule

// File: tb/tb_block_store.sv
// Randomized bench for block_store: expected writes are derived per block from
// base+k and the k-th word slice, with cycle-accurate latency and stall accounting.
module tb_block_store;

    localparam int BLOCK_W = 4096;
    localparam int WORD_W  = 128;
    localparam int ADDR_W  = 16;
    localparam int NWORDS  = BLOCK_W / WORD_W;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_data = '0;
    logic [ADDR_W-1:0]  in_base = '0;
    logic               mem_we;
    logic               mem_ready = 1'b0;
    logic [ADDR_W-1:0]  mem_addr;
    logic [WORD_W-1:0]  mem_wdata;
    logic               busy;
    logic               done;
    logic [15:0]        blk_count;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_count = '0;

    block_store #(.BLOCK_W(BLOCK_W), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_base(in_base),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLOCK_W-1:0] rand_block();
        logic [BLOCK_W-1:0] r;
        for (int i = 0; i < BLOCK_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // stall_mode: 0 = mem always ready, 1 = three stalls on word 5, 2 = random stalls
    task automatic run_block(input string name, input logic [BLOCK_W-1:0] blk,
                             input logic [ADDR_W-1:0] base, input int stall_mode,
                             input logic hold_valid, input logic [BLOCK_W-1:0] next_blk,
                             input logic [ADDR_W-1:0] next_base);
        int   idx = 0, stalls = 0, cyc, stall_left = 0;
        bit   seen_done = 0, stalled5 = 0;
        logic [ADDR_W-1:0] ea;
        logic [WORD_W-1:0] ed;
        check("ready_before_accept", in_ready, 1);
        in_valid  = 1'b1;
        in_data   = blk;
        in_base   = base;
        mem_ready = 1'b1;
        step();
        cyc = 1;
        in_valid = hold_valid;
        in_data  = hold_valid ? next_blk : ~blk;
        in_base  = hold_valid ? next_base : ~base;
        while (!seen_done && cyc < 4 * NWORDS + 50) begin
            case (stall_mode)
                1: begin
                    if (idx == 5 && !stalled5 && mem_we) begin
                        stall_left = 3;
                        stalled5   = 1;
                    end
                    mem_ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
                2: mem_ready = ($urandom_range(3) != 0);
                default: mem_ready = 1'b1;
            endcase
            check("in_ready_low", in_ready, 0);
            if (done) begin
                seen_done = 1;
                exp_count = exp_count + 16'd1;
                check("done_cycle", cyc, NWORDS + 1 + stalls);
                check("words_written", idx, NWORDS);
                check("blk_count", blk_count, exp_count);
                check("busy_in_done", busy, 0);
                check("we_in_done", mem_we, 0);
            end else begin
                check("busy", busy, 1);
                check("mem_we", mem_we, 1);
                if (mem_we) begin
                    if (idx < NWORDS) begin
                        ea = base + ADDR_W'(idx);
                        ed = blk[idx*WORD_W +: WORD_W];
                        check("mem_addr", mem_addr, ea);
                        check("mem_wdata", mem_wdata, ed);
                    end else begin
                        check("extra_write", idx, NWORDS - 1);
                    end
                    if (mem_ready) idx++;
                    else stalls++;
                end
            end
            step();
            cyc++;
        end
        check("done_timeout", seen_done, 1);
        if (seen_done) begin
            check("done_pulse", done, 0);
            check("in_ready_back", in_ready, 1);
            check("busy_idle", busy, 0);
            check("we_idle", mem_we, 0);
        end
        $display("block %s base=%04h stalls=%0d words=%0d blk_count=%0d", name, base, stalls, idx, blk_count);
    endtask

    initial begin
        logic [BLOCK_W-1:0] b1, b2;
        logic [ADDR_W-1:0]  a1, a2;
        int                 n;

        // Reset then idle
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_done", done, 0);
        check("rst_blk_count", blk_count, 0);
        check("rst_mem_addr", mem_addr, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_in_ready", in_ready, 1);
            check("idle_mem_we", mem_we, 0);
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
        end
        $display("reset/idle: in_ready=%0d blk_count=%0d", in_ready, blk_count);

        // Single block, patterned words, no stalls
        for (int k = 0; k < NWORDS; k++) b1[k*WORD_W +: WORD_W] = {16{8'(k)}};
        run_block("pattern", b1, 16'h0100, 0, 1'b0, '0, '0);

        // Backpressure on word 5
        run_block("stall5", rand_block(), 16'h2000, 1, 1'b0, '0, '0);

        // Address wrap
        run_block("wrap", rand_block(), 16'hFFF0, 2, 1'b0, '0, '0);

        // Back-to-back with in_valid held high
        b1 = rand_block();
        b2 = rand_block();
        a1 = 16'(($urandom));
        a2 = 16'(($urandom));
        run_block("b2b_first", b1, a1, 2, 1'b1, b2, a2);
        run_block("b2b_second", b2, a2, 2, 1'b0, '0, '0);

        // Random blocks
        for (int i = 0; i < 4; i++) run_block("random", rand_block(), 16'($urandom), 2, 1'b0, '0, '0);

        // Reset mid-operation after word 10 has been written
        in_valid  = 1'b1;
        in_data   = rand_block();
        in_base   = 16'h0400;
        mem_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 100 && n < 11; c++) begin
            if (mem_we && mem_ready) n++;
            step();
        end
        check("pre_reset_we", mem_we, 1);
        check("pre_reset_addr", mem_addr, 16'h040B);
        #2 rst = 1'b1;
        #1;
        exp_count = '0;
        check("midrst_mem_we", mem_we, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_blk_count", blk_count, exp_count);
        check("midrst_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_hold_we", mem_we, 0);
        end
        #2 rst = 1'b0;
        step();
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_we", mem_we, 0);
        check("post_rst_blk_count", blk_count, exp_count);
        $display("reset mid-block: words before reset=%0d blk_count=%0d", n, blk_count);
        run_block("after_reset", rand_block(), 16'h0777, 2, 1'b0, '0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
